// File: rtl/prog_loader_if.sv
// Stream-in and program-memory write bus of the program loader, plus CPU hold/status.
interface prog_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_instr;
  logic [WIDTH-1:0] mem_arg;
  logic             cpu_hold;
  logic             done;
  logic             err;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_instr, mem_arg, cpu_hold, done, err
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_instr, mem_arg, cpu_hold, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Loads SYNC/LEN/(INSTR,ARG)*N/CSUM frames from a byte stream into program memory,
// holding the CPU until a frame with a good XOR checksum has been written.
module prog_loader #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);
  localparam int unsigned      IW   = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] SYNC = WIDTH'(8'hA5);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_INSTR, S_ARG, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t           state, state_nx;
  logic             rst_q;
  logic [IW-1:0]    idle_cnt;
  logic [WIDTH-1:0] len, word_cnt, cnt_inc, csum;
  logic [WIDTH-1:0] addr_q, instr_q, arg_q;
  logic             we_q;
  logic             accept, in_frame, timeout_hit;
  logic             hold_c, done_c, err_c;

  // Assertion is immediate; release takes effect one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= 1'b0;
    else      rst_q <= 1'b1;
  end

  assign accept      = bus.in_valid && !we_q;
  assign in_frame    = (state == S_LEN) || (state == S_INSTR) ||
                       (state == S_ARG) || (state == S_CSUM);
  assign timeout_hit = in_frame && !accept && (idle_cnt == IW'(TIMEOUT - 1));
  assign cnt_inc     = word_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    hold_c   = (state != S_DONE);
    done_c   = (state == S_DONE);
    err_c    = (state == S_ERR);
    if (timeout_hit) begin
      state_nx = S_ERR;
    end else if (accept) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (bus.in_data == SYNC) state_nx = S_LEN;
        S_LEN:   state_nx = (bus.in_data == '0) ? S_ERR : S_INSTR;
        S_INSTR: state_nx = S_ARG;
        S_ARG:   state_nx = (cnt_inc < len) ? S_INSTR : S_CSUM;
        S_CSUM:  state_nx = (bus.in_data == csum) ? S_DONE : S_ERR;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // The write strobe is registered, so a timeout right after ARG cannot cancel it.
  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      idle_cnt <= '0;
      len      <= '0;
      word_cnt <= '0;
      csum     <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      arg_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      idle_cnt <= (in_frame && !accept) ? idle_cnt + 1'b1 : '0;
      if (accept) begin
        case (state)
          S_LEN: if (bus.in_data != '0) begin
            len      <= bus.in_data;
            word_cnt <= '0;
            addr_q   <= '0;
            csum     <= bus.in_data;
          end
          S_INSTR: begin
            instr_q <= bus.in_data;
            csum    <= csum ^ bus.in_data;
          end
          S_ARG: begin
            arg_q    <= bus.in_data;
            csum     <= csum ^ bus.in_data;
            addr_q   <= word_cnt;
            word_cnt <= cnt_inc;
            we_q     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = !we_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_instr = instr_q;
  assign bus.mem_arg   = arg_q;
  assign bus.cpu_hold  = hold_c;
  assign bus.done      = done_c;
  assign bus.err       = err_c;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of per-cycle vectors plus hand-written
// timeout, mid-frame reset, reset-release and N=255 sequences.
module tb_prog_loader;
  localparam int unsigned TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.WIDTH(8)) bus ();
  prog_loader #(.WIDTH(8), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  always @(negedge clk) if (bus.mem_we) we_cnt++;

  // flags = {mem_we, in_ready, cpu_hold, done, err}
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [4:0] f;
    logic [7:0] a, i, g;
  } vec_t;
  vec_t tbl[$];

  localparam logic [4:0] F_RUN  = 5'b01100;
  localparam logic [4:0] F_WR   = 5'b10100;
  localparam logic [4:0] F_DONE = 5'b01010;
  localparam logic [4:0] F_ERR  = 5'b01101;

  function automatic vec_t mk(logic v, logic [7:0] d, logic [4:0] f,
                              logic [7:0] a = 8'h00, logic [7:0] i = 8'h00, logic [7:0] g = 8'h00);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.a = a; r.i = i; r.g = g;
    return r;
  endfunction

  function automatic logic [4:0] flags();
    return {bus.mem_we, bus.in_ready, bus.cpu_hold, bus.done, bus.err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    logic [7:0] cs, ins, arg;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // garbage then good frame
    tbl.push_back(mk(1, 8'h00, F_RUN));
    tbl.push_back(mk(1, 8'hFF, F_RUN));
    tbl.push_back(mk(1, 8'h5A, F_RUN));
    tbl.push_back(mk(1, 8'hA5, F_RUN));
    tbl.push_back(mk(1, 8'h02, F_RUN));
    tbl.push_back(mk(1, 8'h11, F_RUN));
    tbl.push_back(mk(1, 8'h22, F_WR, 8'h00, 8'h11, 8'h22));
    tbl.push_back(mk(1, 8'h33, F_RUN));   // offered in the bubble: must not transfer
    tbl.push_back(mk(1, 8'h33, F_RUN));
    tbl.push_back(mk(1, 8'h44, F_WR, 8'h01, 8'h33, 8'h44));
    tbl.push_back(mk(0, 8'h00, F_RUN));
    tbl.push_back(mk(1, 8'h46, F_DONE));
    tbl.push_back(mk(1, 8'h77, F_DONE));
    // same frame, bad checksum
    tbl.push_back(mk(1, 8'hA5, F_RUN));
    tbl.push_back(mk(1, 8'h02, F_RUN));
    tbl.push_back(mk(1, 8'h11, F_RUN));
    tbl.push_back(mk(1, 8'h22, F_WR, 8'h00, 8'h11, 8'h22));
    tbl.push_back(mk(0, 8'h00, F_RUN));
    tbl.push_back(mk(1, 8'h33, F_RUN));
    tbl.push_back(mk(1, 8'h44, F_WR, 8'h01, 8'h33, 8'h44));
    tbl.push_back(mk(0, 8'h00, F_RUN));
    tbl.push_back(mk(1, 8'h47, F_ERR));
    // LEN=0, then a single-pair frame
    tbl.push_back(mk(1, 8'hA5, F_RUN));
    tbl.push_back(mk(1, 8'h00, F_ERR));
    tbl.push_back(mk(1, 8'hA5, F_RUN));
    tbl.push_back(mk(1, 8'h01, F_RUN));
    tbl.push_back(mk(1, 8'hAA, F_RUN));
    tbl.push_back(mk(1, 8'hBB, F_WR, 8'h00, 8'hAA, 8'hBB));
    tbl.push_back(mk(0, 8'h00, F_RUN));
    tbl.push_back(mk(1, 8'h10, F_DONE));

    #12;
    check("reset flags", {27'd0, flags()}, {27'd0, F_RUN});
    check("reset bus", {8'd0, bus.mem_addr, bus.mem_instr, bus.mem_arg}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].d);
      check($sformatf("vec%0d flags", k), {27'd0, flags()}, {27'd0, tbl[k].f});
      if (tbl[k].f[4])
        check($sformatf("vec%0d write", k),
              {8'd0, bus.mem_addr, bus.mem_instr, bus.mem_arg},
              {8'd0, tbl[k].a, tbl[k].i, tbl[k].g});
    end

    // stall after INSTR: error exactly TO idle cycles later, no write
    step(1, 8'hA5); step(1, 8'h01); step(1, 8'hAA);
    w0 = we_cnt;
    repeat (TO - 1) step(0, 8'h00);
    check("timeout early", {31'd0, bus.err}, 32'd0);
    step(0, 8'h00);
    check("timeout flags", {27'd0, flags()}, {27'd0, F_ERR});
    check("timeout no write", we_cnt - w0, 32'd0);

    // reset between pairs
    w0 = we_cnt;
    step(1, 8'hA5); step(1, 8'h02); step(1, 8'h11);
    step(1, 8'h22);
    check("midrst first write", {8'd0, bus.mem_addr, bus.mem_instr, bus.mem_arg}, 32'h00001122);
    step(0, 8'h00);
    step(1, 8'h33);
    #2 rst = 1'b0;
    #1;
    check("midrst flags", {27'd0, flags()}, {27'd0, F_RUN});
    check("midrst bus", {8'd0, bus.mem_addr, bus.mem_instr, bus.mem_arg}, 32'd0);
    step(1, 8'h44); step(1, 8'h44); step(0, 8'h00);
    check("midrst write count", we_cnt - w0, 32'd1);

    // reset release: first accept on the second edge
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk) bus.in_data = 8'h00;
    @(posedge clk); #1;
    check("release timing", {27'd0, flags()}, {27'd0, F_ERR});

    // N=255: addresses 0..254, then checksum
    w0 = we_cnt;
    step(1, 8'hA5);
    step(1, 8'hFF);
    cs = 8'hFF;
    for (int i = 0; i < 255; i++) begin
      ins = 8'(i);
      arg = 8'(i + 3);
      step(1, ins);
      step(1, arg);
      check($sformatf("n255 write %0d", i),
            {bus.mem_we, 7'd0, bus.mem_addr, bus.mem_instr, bus.mem_arg},
            {1'b1, 7'd0, ins, ins, arg});
      cs = cs ^ ins ^ arg;
      step(0, 8'h00);
    end
    step(1, cs);
    check("n255 done", {27'd0, flags()}, {27'd0, F_DONE});
    check("n255 write count", we_cnt - w0, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WIDTH, default 8: instruction, argument, stream byte and program-memory address width.
REQ-002 Parameter TIMEOUT, default 255: maximum idle cycles allowed between accepted bytes inside a frame.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: stream byte present on in_data.
REQ-006 Port in_data, input, WIDTH: stream byte.
REQ-007 Port in_ready, output, 1: loader can accept a byte; a byte transfers when in_valid and in_ready are both 1 at a clock edge.
REQ-008 Port mem_we, output, 1: one-cycle write strobe to the program memory.
REQ-009 Port mem_addr, output, WIDTH: program-memory write address.
REQ-010 Port mem_instr, output, WIDTH: opcode byte to write.
REQ-011 Port mem_arg, output, WIDTH: argument byte to write.
REQ-012 Port cpu_hold, output, 1: drives the PC reset; 1 holds the CPU.
REQ-013 Port done, output, 1: load completed with a good checksum.
REQ-014 Port err, output, 1: load failed.

Function
REQ-015 Frame format SHALL be: SYNC byte 8'hA5, then LEN byte N, then N pairs (INSTR, ARG), then CSUM byte.
REQ-016 FSM states SHALL be IDLE, LEN, INSTR, ARG, CSUM, DONE, ERR.
REQ-017 IDLE: accepted 8'hA5 -> LEN; any other accepted byte is discarded and the FSM stays in IDLE.
REQ-018 LEN: accepted N=0 -> ERR; N>0 -> latch N, clear the word counter and the address, seed the checksum with N, then go to INSTR.
REQ-019 INSTR: accepted byte is latched as the opcode and XORed into the checksum, then the FSM goes to ARG.
REQ-020 ARG: accepted byte is latched as the argument and XORed into the checksum, and a write is scheduled.
- Go to INSTR if the word count after this pair is less than N.
- Go to CSUM otherwise.
REQ-021 Write timing: mem_we SHALL be 1 for exactly the cycle after the ARG byte is accepted.
- mem_addr, mem_instr and mem_arg are registered and valid during that cycle.
- mem_addr increments by 1 after each write; the first write goes to address 0.
REQ-022 in_ready SHALL be 1 in every state except the mem_we cycle, where it is 0 (one-cycle bubble).
REQ-023 CSUM: accepted byte equal to the running XOR -> DONE; otherwise -> ERR.
REQ-024 cpu_hold SHALL be 0 only in DONE and 1 in all other states, including ERR.
REQ-025 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-026 DONE and ERR: accepted 8'hA5 restarts the load and goes to LEN, clearing done and err and raising cpu_hold in the same cycle; other bytes are ignored.
REQ-027 Timeout: in LEN, INSTR, ARG or CSUM, an idle counter clears on every accepted byte and increments on every other cycle.
- Reaching TIMEOUT -> ERR.
- No pending write is lost: a write already scheduled by REQ-020 is still issued.
REQ-028 Counter arithmetic: the word counter is WIDTH bits, so N=255 gives addresses 0..254 with no wrap; the address never exceeds N-1.
REQ-029 A byte offered while in_ready=0 SHALL NOT transfer and SHALL NOT alter state.

Reset
REQ-030 On rst=0, the FSM SHALL go to IDLE asynchronously.
- cpu_hold=1, in_ready=1.
- mem_we, done and err = 0.
- mem_addr, mem_instr, mem_arg, counters and checksum = 0.
REQ-031 Reset asserted mid-frame SHALL abort the load with no further mem_we pulse; the memory contents already written are left as they are.
REQ-032 Reset release is synchronised internally; the first byte can be accepted on the second rising edge after rst returns to 1.

Verification
REQ-033 Good frame A5,02,11,22,33,44,CSUM=02^11^22^33^44=0x46 -> write (0,11,22), then write (1,33,44); done=1, cpu_hold=0, err=0.
REQ-034 Same frame with CSUM=0x47 -> both writes occur, err=1, cpu_hold stays 1.
REQ-035 LEN=00 -> err=1, no mem_we pulse; then A5,01,AA,BB,CSUM=0x10 -> done=1.
REQ-036 Garbage 00,FF,5A before A5 -> discarded; the frame that follows loads normally.
REQ-037 Stall longer than TIMEOUT cycles after an INSTR byte -> err=1, no mem_we pulse for that pair.
REQ-038 rst=0 between the two pairs of REQ-033 -> only the address-0 write occurs; outputs return to their reset values immediately.
